// File: rtl/el2_pkg.sv
// -----------------------------------------------------------------------------
// el2_pkg
// Shared types and constants used by the DCCM initialization sequencer.
//   el2_dccm_init_state_t : sequencer state (IDLE pass-through, FILL zeroing)
//   EL2_DCCM_ZERO_CW      : 39-bit all-zero word, a valid SECDED codeword
// -----------------------------------------------------------------------------
package el2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } el2_dccm_init_state_t;

    // 32 data bits + 7 ECC bits; all-zero data encodes to all-zero check bits.
    localparam logic [38:0] EL2_DCCM_ZERO_CW = 39'b0;

endpackage

// File: rtl/el2_dccm_init_ctr.sv
// -----------------------------------------------------------------------------
// el2_dccm_init_ctr
// Fill address counter for the DCCM init sequencer. One count per fill cycle;
// each count addresses one 64-bit row (two 32-bit words).
// Ports:
//   clk, rst   : core clock, synchronous active-high reset (clears count)
//   load_zero  : load count with zero (has priority over inc)
//   inc        : increment count, wrapping at all-ones
//   cnt        : current count
//   tc         : terminal count, high when cnt is all ones
// -----------------------------------------------------------------------------
module el2_dccm_init_ctr #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_zero,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Natural binary wrap takes the counter back to zero after the last row,
    // so the next fill needs no extra clear.
    always_comb begin
        cnt_d = cnt_q;
        if (load_zero) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = &cnt_q;

endmodule

// File: rtl/el2_dccm_init_seq.sv
// -----------------------------------------------------------------------------
// el2_dccm_init_seq
// DCCM initialization sequencer placed in front of the memory wrapper's DCCM
// port group. After reset (AUTO_INIT=1) or on init_start it writes the zero
// codeword to every DCCM location, two words per cycle, stalling the LSU.
// In IDLE the LSU DCCM port is passed straight through combinationally.
// Ports:
//   clk, rst            : core clock, synchronous active-high reset
//   init_start          : one-cycle fill request, honoured only in IDLE
//   init_busy           : fill in progress (flop output)
//   init_done           : sticky fill-complete flag (flop output)
//   lsu_dccm_stall      : LSU must hold its request (same as init_busy)
//   lsu_dccm_*          : LSU-side DCCM request
//   dccm_*              : memory-wrapper-side DCCM request
// -----------------------------------------------------------------------------
module el2_dccm_init_seq
    import el2_pkg::*;
#(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int AUTO_INIT        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        init_start,
    output logic                        init_busy,
    output logic                        init_done,
    output logic                        lsu_dccm_stall,

    input  logic                        lsu_dccm_wren,
    input  logic                        lsu_dccm_rden,
    input  logic [DCCM_BITS-1:0]        lsu_dccm_wr_addr_lo,
    input  logic [DCCM_BITS-1:0]        lsu_dccm_wr_addr_hi,
    input  logic [DCCM_BITS-1:0]        lsu_dccm_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        lsu_dccm_rd_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_dccm_wr_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] lsu_dccm_wr_data_hi,

    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi
);

    localparam int CNT_W = DCCM_BITS - 3;

    localparam el2_dccm_init_state_t RESET_STATE = (AUTO_INIT != 0) ? FILL : IDLE;

    localparam logic [DCCM_FDATA_WIDTH-1:0] ZERO_DATA =
        DCCM_FDATA_WIDTH'(EL2_DCCM_ZERO_CW);

    el2_dccm_init_state_t state_q;
    el2_dccm_init_state_t state_d;
    logic                 done_q;
    logic                 done_d;

    logic                 ctr_load;
    logic                 ctr_inc;
    logic [CNT_W-1:0]     cnt;
    logic                 cnt_tc;

    el2_dccm_init_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_zero (ctr_load),
        .inc       (ctr_inc),
        .cnt       (cnt),
        .tc        (cnt_tc)
    );

    // Next-state logic. A fill request is only looked at in IDLE, so a request
    // during FILL (including on the last fill write) is dropped.
    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d  = FILL;
                    done_d   = 1'b0;
                    ctr_load = 1'b1;
                end
            end
            FILL: begin
                ctr_inc = 1'b1;
                if (cnt_tc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign init_busy      = (state_q == FILL);
    assign init_done      = done_q;
    assign lsu_dccm_stall = init_busy;

    // Output mux. The enables are gated by rst so nothing reaches memory while
    // reset is held, even from a fill that is being aborted.
    always_comb begin
        dccm_wren       = lsu_dccm_wren;
        dccm_rden       = lsu_dccm_rden;
        dccm_wr_addr_lo = lsu_dccm_wr_addr_lo;
        dccm_wr_addr_hi = lsu_dccm_wr_addr_hi;
        dccm_rd_addr_lo = lsu_dccm_rd_addr_lo;
        dccm_rd_addr_hi = lsu_dccm_rd_addr_hi;
        dccm_wr_data_lo = lsu_dccm_wr_data_lo;
        dccm_wr_data_hi = lsu_dccm_wr_data_hi;
        if (state_q == FILL) begin
            dccm_wren       = 1'b1;
            dccm_rden       = 1'b0;
            dccm_wr_addr_lo = {cnt, 3'b000};
            dccm_wr_addr_hi = {cnt, 3'b100};
            dccm_rd_addr_lo = '0;
            dccm_rd_addr_hi = '0;
            dccm_wr_data_lo = ZERO_DATA;
            dccm_wr_data_hi = ZERO_DATA;
        end
        if (rst) begin
            dccm_wren = 1'b0;
            dccm_rden = 1'b0;
        end
    end

endmodule
